// File: rtl/instr_writer_pkg.sv
// Shared types and constants for the instruction writer: record kinds,
// RV32I opcodes, word/tag types and the decoded-record payload.
package instr_writer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned KIND_W = 3;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned OPC_W  = 7;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [KIND_W-1:0] {
    KIND_REG    = 3'd0,
    KIND_IMM    = 3'd1,
    KIND_JAL    = 3'd2,
    KIND_JALR   = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_LOAD   = 3'd5,
    KIND_STORE  = 3'd6,
    KIND_ILL    = 3'd7
  } kind_e;

  localparam logic [OPC_W-1:0] opcode_reg    = 7'h33;
  localparam logic [OPC_W-1:0] opcode_imm    = 7'h13;
  localparam logic [OPC_W-1:0] opcode_jal    = 7'h6F;
  localparam logic [OPC_W-1:0] opcode_jalr   = 7'h67;
  localparam logic [OPC_W-1:0] opcode_branch = 7'h63;
  localparam logic [OPC_W-1:0] opcode_load   = 7'h03;
  localparam logic [OPC_W-1:0] opcode_store  = 7'h23;

  typedef struct packed {
    kind_e             kind;
    logic [F3_W-1:0]   funct3;
    logic              sub;
    tag_t              rs1;
    tag_t              rs2;
    tag_t              rd;
    word_t             imm;
  } record_t;

endpackage

// File: rtl/instr_writer_if.sv
// Record input channel plus instruction-memory write port.
interface instr_writer_if #(
  parameter int unsigned ADDR_W = 12
);
  import instr_writer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [KIND_W-1:0] in_kind;
  logic [F3_W-1:0]   in_funct3;
  logic              in_sub;
  tag_t              in_rs1;
  tag_t              in_rs2;
  tag_t              in_rd;
  word_t             in_imm;

  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;

  // Program source side: drives records, provides memory backpressure.
  modport master (
    output in_valid, in_last, in_kind, in_funct3, in_sub,
           in_rs1, in_rs2, in_rd, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Writer side: consumes records, drives the memory write port.
  modport slave (
    input  in_valid, in_last, in_kind, in_funct3, in_sub,
           in_rs1, in_rs2, in_rd, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_writer_encode.sv
// Combinational packer: decoded record -> 32-bit RV32I line plus illegal flag.
// Optional build macro: INSTR_WRITER_RANGE_CHECK_EN (reject out-of-range immediates).
module instr_encode
  import instr_writer_pkg::*;
(
  input  record_t rec,
  output word_t   line,
  output logic    illegal
);

  logic range_bad;

`ifdef INSTR_WRITER_RANGE_CHECK_EN
  logic signed [WORD_W-1:0] simm;
  assign simm = signed'(rec.imm);

  // Immediate must fit its field (and be even for pc-relative targets).
  always_comb begin
    range_bad = 1'b0;
    case (rec.kind)
      KIND_IMM, KIND_LOAD, KIND_JALR, KIND_STORE:
        range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      KIND_BRANCH:
        range_bad = rec.imm[0] || (simm < -32'sd4096) || (simm > 32'sd4094);
      KIND_JAL:
        range_bad = rec.imm[0] || (simm < -32'sd1048576) || (simm > 32'sd1048574);
      default:
        range_bad = 1'b0;
    endcase
  end
`else
  // Without the check the immediate is truncated to its field bits.
  logic unused_imm_hi;
  assign unused_imm_hi = ^rec.imm[WORD_W-1:21];
  assign range_bad     = 1'b0;
`endif

  // Field packing per instruction format.
  always_comb begin
    line    = '0;
    illegal = range_bad;
    case (rec.kind)
      KIND_REG:    line = {(rec.sub ? 7'h20 : 7'h00), rec.rs2, rec.rs1, rec.funct3,
                           rec.rd, opcode_reg};
      KIND_IMM:    line = {(rec.sub ? 7'h20 : rec.imm[11:5]), rec.imm[4:0], rec.rs1,
                           rec.funct3, rec.rd, opcode_imm};
      KIND_LOAD:   line = {rec.imm[11:0], rec.rs1, rec.funct3, rec.rd, opcode_load};
      KIND_JALR:   line = {rec.imm[11:0], rec.rs1, 3'b000, rec.rd, opcode_jalr};
      KIND_JAL:    line = {rec.imm[20], rec.imm[10:1], rec.imm[11], rec.imm[19:12],
                           rec.rd, opcode_jal};
      KIND_BRANCH: line = {rec.imm[12], rec.imm[10:5], rec.rs2, rec.rs1, rec.funct3,
                           rec.imm[4:1], rec.imm[11], opcode_branch};
      KIND_STORE:  line = {rec.imm[11:5], rec.rs2, rec.rs1, rec.funct3, rec.imm[4:0],
                           opcode_store};
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_writer.sv
// Program loader: accepts decoded records, encodes them and writes the lines
// sequentially into instruction memory with a one-deep write pipe.
// Optional build macro: INSTR_WRITER_RANGE_CHECK_EN (see instr_encode).
module instr_writer
  import instr_writer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned COUNT_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  instr_writer_if.slave      bus,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state, state_next;
  logic              done_next;
  logic              pipe_valid;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;
  logic              in_ready_c, accept_c, write_done_c, launch_c;
  record_t           rec;
  word_t             enc_line;
  logic              enc_illegal;
  logic              unused_base_lo;

  assign unused_base_lo = ^base_addr[1:0];

  assign in_ready_c   = (state == RUN) && (!pipe_valid || bus.mem_ready);
  assign accept_c     = bus.in_valid && in_ready_c;
  assign write_done_c = pipe_valid && bus.mem_ready;
  assign launch_c     = (state == IDLE) && start;

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = pipe_valid;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign rec = '{kind:   kind_e'(bus.in_kind),
                 funct3: bus.in_funct3,
                 sub:    bus.in_sub,
                 rs1:    bus.in_rs1,
                 rs2:    bus.in_rs2,
                 rd:     bus.in_rd,
                 imm:    bus.in_imm};

  instr_encode u_encode (
    .rec     (rec),
    .line    (enc_line),
    .illegal (enc_illegal)
  );

  // Control FSM next state and done pulse.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (accept_c && bus.in_last) state_next = DRAIN;
      DRAIN: if (!pipe_valid || write_done_c) begin
               state_next = IDLE;
               done_next  = 1'b1;
             end
      default: state_next = IDLE;
    endcase
  end

  // Control state and registered status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= done_next;
    end
  end

  // Write pipe, address/count tracking and sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      count      <= '0;
      error      <= 1'b0;
    end else if (launch_c) begin
      pipe_valid <= 1'b0;
      mem_addr   <= {base_addr[ADDR_W-1:2], 2'b00};
      count      <= '0;
      error      <= 1'b0;
    end else begin
      if (write_done_c) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        if (count != {COUNT_W{1'b1}}) count <= count + COUNT_W'(1);
      end
      if (accept_c) begin
        pipe_valid <= !enc_illegal;
        if (enc_illegal) error     <= 1'b1;
        else             mem_wdata <= enc_line;
      end else if (write_done_c) begin
        pipe_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_writer.sv
// Directed self-checking bench for instr_writer.
module tb_instr_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic        busy, done, error;
  logic [9:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  instr_writer_if #(.ADDR_W(12)) bus ();

  instr_writer #(.ADDR_W(12), .COUNT_W(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .error     (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log completed writes and done pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.mem_we && bus.mem_ready) begin
      wr_addr.push_back(32'(bus.mem_addr));
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Immediate recovered from an encoded line, independent of the encoder.
  function automatic logic [31:0] dec_imm(input logic [31:0] l);
    case (l[6:0])
      7'h6F:   dec_imm = {{12{l[31]}}, l[19:12], l[20], l[30:21], 1'b0};
      7'h63:   dec_imm = {{20{l[31]}}, l[7], l[30:25], l[11:8], 1'b0};
      7'h23:   dec_imm = {{21{l[31]}}, l[30:25], l[11:7]};
      default: dec_imm = {{21{l[31]}}, l[30:20]};
    endcase
  endfunction

  // All tasks below are entered and left 1 time unit after a rising edge.
  task automatic prog(input logic [11:0] b);
    base_addr = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic sb,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic [31:0] im, input logic last);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1; bus.in_kind = k; bus.in_funct3 = f3; bus.in_sub = sb;
    bus.in_rs1 = r1; bus.in_rs2 = r2; bus.in_rd = rd; bus.in_imm = im; bus.in_last = last;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
    @(posedge clock); #1;
  endtask

  int w0, d0;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_kind = '0; bus.in_funct3 = '0;
    bus.in_sub = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_imm = '0;
    bus.mem_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata,    32'd0);
    check("rst_flags", {28'd0, busy, done, error, 1'b0}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // add / sub pair with done pulse.
    w0 = wr_data.size(); d0 = done_cnt;
    prog(12'h100);
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    wait_idle();
    check("t1_nwr",   32'(wr_data.size() - w0), 32'd2);
    check("t1_d0",    wr_data[w0],     32'h002081B3);
    check("t1_a0",    wr_addr[w0],     32'h100);
    check("t1_d1",    wr_data[w0+1],   32'h402081B3);
    check("t1_a1",    wr_addr[w0+1],   32'h104);
    check("t1_done",  32'(done_cnt - d0), 32'd1);
    check("t1_count", 32'(count), 32'd2);
    check("t1_error", 32'(error), 32'd0);

    // addi, jal, srai back to back.
    w0 = wr_data.size();
    prog(12'h200);
    send(3'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b0);
    send(3'd2, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0);
    send(3'd1, 3'd5, 1'b1, 5'd1, 5'd0, 5'd1, 32'd3, 1'b1);
    wait_idle();
    check("t2_nwr",  32'(wr_data.size() - w0), 32'd3);
    check("t2_addi", wr_data[w0],   32'hFFF00093);
    check("t2_jal",  wr_data[w0+1], 32'h008000EF);
    check("t2_srai", wr_data[w0+2], 32'h4030D093);
    check("t2_a2",   wr_addr[w0+2], 32'h208);
    check("t2_b2b",  32'(wr_cyc[w0+1] - wr_cyc[w0]), 32'd1);
    check("t2_jal_rt", dec_imm(wr_data[w0+1]), 32'd8);
    check("t2_count", 32'(count), 32'd3);

    // branch held under backpressure, then store.
    w0 = wr_data.size();
    prog(12'h300);
    bus.mem_ready = 1'b0;
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0);
    fork
      send(3'd6, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b1);
      begin
        repeat (3) begin
          @(negedge clock);
          check("t3_stall_we",    32'(bus.mem_we),   32'd1);
          check("t3_stall_data",  bus.mem_wdata,     32'hFE208EE3);
          check("t3_stall_addr",  32'(bus.mem_addr), 32'h300);
          check("t3_stall_ready", 32'(bus.in_ready), 32'd0);
          @(posedge clock);
        end
        #1 bus.mem_ready = 1'b1;
      end
    join
    wait_idle();
    check("t3_nwr",    32'(wr_data.size() - w0), 32'd2);
    check("t3_br",     wr_data[w0],   32'hFE208EE3);
    check("t3_st",     wr_data[w0+1], 32'h0020A423);
    check("t3_a1",     wr_addr[w0+1], 32'h304);
    check("t3_br_rt",  dec_imm(wr_data[w0]),   32'hFFFF_FFFC);
    check("t3_st_rt",  dec_imm(wr_data[w0+1]), 32'd8);
    check("t3_st_rs",  {22'd0, wr_data[w0+1][24:20], wr_data[w0+1][19:15]}, {22'd0, 5'd2, 5'd1});

    // Address wrap at the top of memory; low base bits ignored.
    w0 = wr_data.size();
    prog(12'hFFD);
    send(3'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd2, 32'd2, 1'b1);
    wait_idle();
    check("t4_a0", wr_addr[w0],   32'hFFC);
    check("t4_a1", wr_addr[w0+1], 32'h000);
    check("t4_d0", wr_data[w0],   32'h00100093);
    check("t4_d1", wr_data[w0+1], 32'h00208113);

    // Illegal kind with last: no write, error, done still pulses.
    w0 = wr_data.size(); d0 = done_cnt;
    prog(12'h000);
    send(3'd7, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd4096, 1'b1);
    wait_idle();
    check("t5_nwr",   32'(wr_data.size() - w0), 32'd0);
    check("t5_error", 32'(error), 32'd1);
    check("t5_done",  32'(done_cnt - d0), 32'd1);
    check("t5_count", 32'(count), 32'd0);

    // Reset while a write is stalled.
    prog(12'h080);
    check("t6_err_clr", 32'(error), 32'd0);
    bus.mem_ready = 1'b0;
    send(3'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'd7, 1'b0);
    @(negedge clock);
    check("t6_pre_we", 32'(bus.mem_we), 32'd1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("t6_we",    32'(bus.mem_we),   32'd0);
    check("t6_addr",  32'(bus.mem_addr), 32'd0);
    check("t6_wdata", bus.mem_wdata,     32'd0);
    check("t6_flags", {28'd0, busy, done, error, bus.in_ready}, 32'd0);
    check("t6_count", 32'(count), 32'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clock); #1;

    // Normal program after reset.
    w0 = wr_data.size();
    prog(12'h040);
    send(3'd6, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b1);
    wait_idle();
    check("t7_nwr",   32'(wr_data.size() - w0), 32'd1);
    check("t7_addr",  wr_addr[w0], 32'h040);
    check("t7_data",  wr_data[w0], 32'h0020A423);
    check("t7_done",  32'(done_cnt - d0), 32'd1);
    check("t7_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_writer.md
Name: instr_writer

Overview:
- Reverse of the stage-2 decoder: accepts decoded-form instruction records (kind, funct3, sub flag, rs1/rs2/rd tags, word immediate) and packs each into a 32-bit RV32I line.
- Writes lines sequentially into instruction memory through a write port with backpressure.
- Used by the bench/boot path to load programs into the fetch stage's memory.
- Two-state pipeline (accept register, then write) under a small control FSM.

Parameters:
- ADDR_W, 12, byte-address width of the instruction memory write port; addresses wrap modulo 2^ADDR_W.
- COUNT_W, 10, width of the written-instruction counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  in IDLE: load base_addr, clear count and error, enter RUN.
- base_addr  in  ADDR_W  first write address; bits [1:0] ignored, treated as 0.
- in_valid  in  1  record valid.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_last  in  1  marks the final record of the program.
- in_kind  in  3  record kind: 0 reg, 1 imm, 2 jal, 3 jalr, 4 branch, 5 load, 6 store; 7 is illegal.
- in_funct3  in  3  funct3 field.
- in_sub  in  1  reg: funct7 = 0x20; imm: imm[11:5] forced to 0x20 (srai).
- in_rs1, in_rs2, in_rd  in  5 each  register tags.
- in_imm  in  32  sign-extended byte immediate.
- mem_we  out  1  write strobe.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- mem_addr  out  ADDR_W  word-aligned write address.
- mem_wdata  out  32  encoded line.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last write completes.
- count  out  COUNT_W  number of lines written since start; saturates at the maximum value.
- error  out  1  sticky; set on an illegal kind or, with the optional feature, an out-of-range immediate; cleared by start.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready, mem_we, done, error, busy = 0.
  - mem_addr, mem_wdata, count = 0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: an accepted record with in_last -> DRAIN.
  - DRAIN: when the pipe register is empty (or its write completes that cycle) -> pulse done and go to IDLE.
  - start outside IDLE is ignored.
- Handshake:
  - in_ready = (state == RUN) && (!pipe_valid || mem_ready).
  - An accepted record is encoded combinationally and registered into the pipe.
  - Write latency: mem_we = pipe_valid, asserted the cycle after acceptance.
  - mem_addr, mem_wdata and mem_we hold stable until mem_ready.
  - Accept and write-complete in the same cycle: the pipe reloads and throughput is 1 line/cycle.
- On each completed write: mem_addr += 4 (wraps from 2^ADDR_W-4 to 0); count += 1.
- Encoding (opcodes 33, 13, 6F, 67, 63, 03, 23 hex):
  - reg: {sub ? 7'h20 : 7'h00, rs2, rs1, f3, rd, op}.
  - imm, load, jalr: {imm[11:0], rs1, f3, rd, op}; jalr forces f3 = 0.
  - jal: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - branch: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - store: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
- Illegal kind 7: the record is accepted but not written; error is set. If in_last is set, DRAIN still follows.
- Reset mid-write: mem_we drops immediately, the partial program is abandoned, and no done pulse is issued.
- In-range immediates must round-trip through the decoder to the same fields.

Optional Feature:
- Macro: INSTR_WRITER_RANGE_CHECK_EN.
- Defined: the record is rejected as illegal (accepted, not written, error set, count unchanged) when its immediate is out of range:
  - imm/load/jalr/store: outside [-2048, 2047].
  - branch: odd, or outside [-4096, 4094].
  - jal: odd, or outside [-2^20, 2^20-2].
- Undefined: no range check; the immediate is silently truncated to its field bits, and only kind 7 sets error.

Decomposition:
- Shared package / definitions.vh:
  - kind enum constants.
  - opcode constants (reuse the existing opcode_* macros).
  - word and tag typedefs.
- One sub-module: instr_encode, purely combinational. It maps {kind, f3, sub, rs1, rs2, rd, imm} to {line, illegal} and is reused by the bench's decoder round-trip check.

Test Plan:
- start, base 0x100; reg x3=x1+x2 (sub=0) then sub=1 with last -> writes 0x002081B3 @0x100, then 0x402081B3 @0x104; done pulse; count = 2.
- imm addi x1,x0,-1; jal rd=1 imm=8 -> 0xFFF00093, then 0x008000EF, on back-to-back cycles.
- branch beq x1,x2,-4; store sw x2,8(x1) with mem_ready held low 3 cycles -> 0xFE208EE3 held stable on the port, then 0x0020A423; in_ready low while stalled.
- base 0xFFC with ADDR_W = 12, two records -> writes @0xFFC, then @0x000.
- kind 7 with last (and imm = 4096 under INSTR_WRITER_RANGE_CHECK_EN) -> no mem_we; error = 1; done pulses; count = 0.
- Reset asserted while mem_we is high with mem_ready low -> outputs reach 0 asynchronously; next start works normally.
